// File: rtl/oscillator_pkg.sv
// Shared constants and helpers for the oscillator bank: FSM state codes,
// default gains and saturation bound helpers.
package oscillator_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_KV_SHIFT = 7;
    localparam int DEF_KP_SHIFT = 8;
    localparam int DEF_FB_SHIFT = 8;
    localparam int DEF_INIT_POS = 4915;
    localparam int DEF_NEUTRAL  = 0;

    function automatic int sat_hi(int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(int w);
        return -(1 << (w - 1));
    endfunction

    // Position (Q.FRAC) to output sample: arithmetic shift, then clamp.
    function automatic int scale_pos(int p, int shift, int w);
        int s;
        s = p >>> shift;
        if (s > sat_hi(w)) s = sat_hi(w);
        if (s < sat_lo(w)) s = sat_lo(w);
        return s;
    endfunction

endpackage

// File: rtl/oscillator_bank_if.sv
// Control/data bundle between the oscillator bank and its host.
interface oscillator_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    logic                         tick;
    logic                         clear;
    logic [CHANNELS*WIDTH-1:0]    feedback;
    logic [CHANNELS*WIDTH-1:0]    positionOut;
    logic                         busy;
    logic                         done;
    logic                         overrun;

    modport master (
        output tick, clear, feedback,
        input  positionOut, busy, done, overrun
    );

    modport slave (
        input  tick, clear, feedback,
        output positionOut, busy, done, overrun
    );
endinterface

// File: rtl/oscillator_step.sv
// Combinational single-channel integration step with saturating state
// and clamped output sample. Shared by all channels in turn.
module oscillator_step
    import oscillator_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FRAC     = 14,
    parameter int STATE_W  = 18,
    parameter int KV_SHIFT = DEF_KV_SHIFT,
    parameter int KP_SHIFT = DEF_KP_SHIFT,
    parameter int FB_SHIFT = DEF_FB_SHIFT,
    parameter int NEUTRAL  = DEF_NEUTRAL
) (
    input  logic signed [STATE_W-1:0] pos,
    input  logic signed [STATE_W-1:0] vel,
    input  logic signed [WIDTH-1:0]   fb,
    output logic signed [STATE_W-1:0] posNext,
    output logic signed [STATE_W-1:0] velNext,
    output logic signed [WIDTH-1:0]   sample
);
    // Three guard bits keep the sum of three shifted terms from wrapping.
    localparam int EW        = STATE_W + 3;
    localparam int OUT_SHIFT = FRAC - WIDTH + 1;
    localparam logic signed [EW-1:0] STATE_HI  = EW'(sat_hi(STATE_W));
    localparam logic signed [EW-1:0] STATE_LO  = EW'(sat_lo(STATE_W));
    localparam logic signed [EW-1:0] OUT_HI    = EW'(sat_hi(WIDTH));
    localparam logic signed [EW-1:0] OUT_LO    = EW'(sat_lo(WIDTH));
    localparam logic signed [EW-1:0] NEUTRAL_E = EW'(NEUTRAL);

    function automatic logic signed [EW-1:0] clamp(
        input logic signed [EW-1:0] v,
        input logic signed [EW-1:0] lo,
        input logic signed [EW-1:0] hi
    );
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    logic signed [EW-1:0] posE, velE, fbq, acc, posSat, velSat, outSat;

    // Both updates read the old pos/vel; the sample is taken from the new pos.
    always_comb begin
        posE    = {{3{pos[STATE_W-1]}}, pos};
        velE    = {{3{vel[STATE_W-1]}}, vel};
        fbq     = {{(EW-WIDTH){fb[WIDTH-1]}}, fb} <<< OUT_SHIFT;
        acc     = -(velE >>> KV_SHIFT)
                  - ((posE - NEUTRAL_E) >>> KP_SHIFT)
                  - (fbq >>> FB_SHIFT);
        posSat  = clamp(posE + velE, STATE_LO, STATE_HI);
        velSat  = clamp(velE + acc, STATE_LO, STATE_HI);
        outSat  = clamp(posSat >>> OUT_SHIFT, OUT_LO, OUT_HI);
        posNext = posSat[STATE_W-1:0];
        velNext = velSat[STATE_W-1:0];
        sample  = outSat[WIDTH-1:0];
    end
endmodule

// File: rtl/oscillator_bank.sv
// Bank of damped oscillators sharing one step datapath. A tick walks the
// channels one per cycle, then publishes all samples at once.
//
//  state   | meaning
//  IDLE    | waiting for tick
//  RUN     | updating channel idx, one per cycle
//  DONE    | step complete, positionOut valid, done high
module oscillator_bank
    import oscillator_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int FRAC     = 14,
    parameter int STATE_W  = 18,
    parameter int KV_SHIFT = DEF_KV_SHIFT,
    parameter int KP_SHIFT = DEF_KP_SHIFT,
    parameter int FB_SHIFT = DEF_FB_SHIFT,
    parameter int INIT_POS = DEF_INIT_POS,
    parameter int NEUTRAL  = DEF_NEUTRAL
) (
    input logic             clock,
    input logic             resetN,
    oscillator_bank_if.slave bus
);
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IW-1:0]               LAST     = IW'(CHANNELS - 1);
    localparam logic signed [STATE_W-1:0]   INIT_E   = STATE_W'(INIT_POS);
    localparam logic signed [WIDTH-1:0]     INIT_OUT =
        WIDTH'(scale_pos(INIT_POS, FRAC - WIDTH + 1, WIDTH));

    logic [1:0]                  state;
    logic [IW-1:0]               idx;
    logic [CHANNELS*WIDTH-1:0]   fbLatch;
    logic [CHANNELS*WIDTH-1:0]   stage;
    logic [CHANNELS*WIDTH-1:0]   posOut;
    logic signed [STATE_W-1:0]   posArr [CHANNELS];
    logic signed [STATE_W-1:0]   velArr [CHANNELS];
    logic signed [STATE_W-1:0]   posNext, velNext;
    logic signed [WIDTH-1:0]     sampleNext, fbSel;

    assign fbSel = fbLatch[idx*WIDTH +: WIDTH];

    oscillator_step #(
        .WIDTH(WIDTH), .FRAC(FRAC), .STATE_W(STATE_W),
        .KV_SHIFT(KV_SHIFT), .KP_SHIFT(KP_SHIFT), .FB_SHIFT(FB_SHIFT),
        .NEUTRAL(NEUTRAL)
    ) u_step (
        .pos(posArr[idx]), .vel(velArr[idx]), .fb(fbSel),
        .posNext(posNext), .velNext(velNext), .sample(sampleNext)
    );

    // Sequencer and per-channel state; clear has priority over everything.
    // positionOut is loaded on entry to DONE (last lane straight from the
    // datapath) so it is already valid while done is high.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= ST_IDLE;
            idx     <= '0;
            fbLatch <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                posArr[i]                <= INIT_E;
                velArr[i]                <= '0;
                stage[i*WIDTH +: WIDTH]  <= INIT_OUT;
                posOut[i*WIDTH +: WIDTH] <= INIT_OUT;
            end
        end else if (bus.clear) begin
            state <= ST_IDLE;
            idx   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                posArr[i]                <= INIT_E;
                velArr[i]                <= '0;
                stage[i*WIDTH +: WIDTH]  <= INIT_OUT;
                posOut[i*WIDTH +: WIDTH] <= INIT_OUT;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.tick) begin
                        fbLatch <= bus.feedback;
                        idx     <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    posArr[idx]               <= posNext;
                    velArr[idx]               <= velNext;
                    stage[idx*WIDTH +: WIDTH] <= sampleNext;
                    if (idx == LAST) begin
                        state <= ST_DONE;
                        for (int i = 0; i < CHANNELS; i++) begin
                            posOut[i*WIDTH +: WIDTH] <= (i == CHANNELS - 1) ?
                                sampleNext : stage[i*WIDTH +: WIDTH];
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.positionOut = posOut;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign bus.overrun     = bus.tick & (state != ST_IDLE) & ~bus.clear;
endmodule

// File: tb/tb_oscillator_bank.sv
// Bench for oscillator_bank: transaction-level model plus directed pins.
module tb_oscillator_bank;
    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int FRAC = 14;
    localparam int SW   = 18;
    localparam int OSH  = FRAC - W + 1;
    localparam int INIT = 4915;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    oscillator_bank_if #(.CHANNELS(CH), .WIDTH(W)) bus();

    oscillator_bank #(.CHANNELS(CH), .WIDTH(W), .FRAC(FRAC), .STATE_W(SW)) dut (
        .clock(clock), .resetN(resetN), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: whole-step arithmetic on plain ints, timing by cycle age.
    int mPos [CH];
    int mVel [CH];
    int mOut [CH];
    int mFb  [CH];
    int age    = -1;
    int mSteps = 0;
    int doneCnt = 0;
    int ovrCnt  = 0;

    function automatic int clampw(int v, int w);
        int hi, lo;
        hi = (2 ** (w - 1)) - 1;
        lo = -(2 ** (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int toOut(int p);
        return clampw(p >>> OSH, W);
    endfunction

    task automatic modelInit();
        for (int c = 0; c < CH; c++) begin
            mPos[c] = INIT;
            mVel[c] = 0;
            mOut[c] = toOut(INIT);
        end
    endtask

    task automatic modelStep();
        int fbq, acc, np, nv;
        for (int c = 0; c < CH; c++) begin
            fbq = mFb[c] * (2 ** OSH);
            acc = -(mVel[c] >>> 7) - (mPos[c] >>> 8) - (fbq >>> 8);
            np  = clampw(mPos[c] + mVel[c], SW);
            nv  = clampw(mVel[c] + acc, SW);
            mPos[c] = np;
            mVel[c] = nv;
            mOut[c] = toOut(np);
        end
    endtask

    always @(posedge clock or negedge resetN) begin
        if (!resetN || bus.clear) begin
            modelInit();
            age = -1;
        end else if (age < 0) begin
            if (bus.tick) begin
                for (int c = 0; c < CH; c++) mFb[c] = $signed(bus.feedback[c*W +: W]);
                age = 0;
            end
        end else if (age == CH) begin
            age = -1;
        end else begin
            age = age + 1;
            if (age == CH) begin
                modelStep();
                mSteps = mSteps + 1;
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lane(int c);
        int v;
        v = $signed(bus.positionOut[c*W +: W]);
        return v;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        chk("busy", int'(bus.busy), int'(age >= 0));
        chk("done", int'(bus.done), int'(age == CH));
        chk("overrun", int'(bus.overrun), int'(bus.tick && age >= 0 && !bus.clear));
        for (int c = 0; c < CH; c++) chk("positionOut", lane(c), mOut[c]);
        if (bus.done) doneCnt = doneCnt + 1;
        if (bus.overrun) ovrCnt = ovrCnt + 1;
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic waitDone(string name, int expLat);
        int i;
        i = 0;
        while (i < 20 && !bus.done) begin
            cyc(1);
            i = i + 1;
        end
        chk(name, int'(bus.done), 1);
        if (expLat >= 0) chk({name, "_latency"}, i, expLat);
    endtask

    int d0, o0, max0, min0, tailMax, v, startSteps, n;

    initial begin
        bus.tick = 1'b0;
        bus.clear = 1'b0;
        bus.feedback = '0;
        cyc(3);
        resetN = 1'b1;
        cyc(1);
        for (int c = 0; c < CH; c++) chk("reset_lane", lane(c), 38);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_overrun", int'(bus.overrun), 0);

        // First and second step with zero feedback.
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        waitDone("step1_done", 4);
        chk("step1_vel0", mVel[0], -19);
        chk("step1_pos0", mPos[0], 4915);
        for (int c = 0; c < CH; c++) chk("step1_lane", lane(c), 38);
        cyc(1);
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        waitDone("step2_done", 4);
        chk("step2_pos0", mPos[0], 4896);
        chk("step2_vel0", mVel[0], -37);
        chk("step2_lane0", lane(0), 38);
        cyc(1);

        // Tick while busy.
        d0 = doneCnt; o0 = ovrCnt;
        bus.tick = 1'b1; cyc(1);
        bus.tick = 1'b0; cyc(1);
        bus.tick = 1'b1; cyc(1);
        bus.tick = 1'b0; cyc(8);
        chk("ovr_done_count", doneCnt - d0, 1);
        chk("ovr_pulse_count", ovrCnt - o0, 1);

        // Clear mid-step.
        d0 = doneCnt;
        bus.tick = 1'b1; cyc(1);
        bus.tick = 1'b0; cyc(2);
        bus.clear = 1'b1; cyc(1);
        bus.clear = 1'b0; cyc(8);
        chk("clear_no_done", doneCnt - d0, 0);
        for (int c = 0; c < CH; c++) chk("clear_lane", lane(c), 38);
        bus.tick = 1'b1; cyc(1);
        bus.tick = 1'b0;
        waitDone("after_clear_done", 4);
        cyc(1);

        // Reset mid-step.
        d0 = doneCnt;
        bus.tick = 1'b1; cyc(1);
        bus.tick = 1'b0; cyc(3);
        resetN = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) chk("rst_lane", lane(c), 38);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        cyc(1);
        resetN = 1'b1;
        cyc(8);
        chk("rst_no_done", doneCnt - d0, 0);

        // Random traffic; feedback keeps changing during steps.
        for (int i = 0; i < 600; i++) begin
            bus.tick     = ($urandom_range(0, 2) == 0);
            bus.clear    = ($urandom_range(0, 40) == 0);
            bus.feedback = $urandom;
            cyc(1);
        end
        bus.tick = 1'b0;
        bus.clear = 1'b1;
        cyc(1);
        bus.clear = 1'b0;

        // Strong negative feedback on lane 0 for 5000 steps.
        bus.feedback = 32'h0000_0080;
        bus.tick = 1'b1;
        startSteps = mSteps;
        max0 = -1000; min0 = 1000; tailMax = 0; n = 0;
        while (mSteps - startSteps < 5000 && n < 40000) begin
            cyc(1);
            n = n + 1;
            v = lane(0);
            if (v > max0) max0 = v;
            if (v < min0) min0 = v;
            if (mSteps - startSteps > 4500) begin
                for (int c = 1; c < CH; c++) begin
                    v = lane(c);
                    if (v < 0) v = -v;
                    if (v > tailMax) tailMax = v;
                end
            end
        end
        bus.tick = 1'b0;
        cyc(8);
        chk("long_steps", int'(mSteps - startSteps >= 5000), 1);
        chk("long_lane0_max", max0, 127);
        chk("long_lane0_nonneg", int'(min0 >= 0), 1);
        chk("long_others_decay", int'(tailMax < 38), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
